if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core.
- Owns the program counter and drives the read address of the instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles stalls, flushes and branch/jump redirects from later stages, plus a boot-wait cycle while the instruction memory loads after reset.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction word
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr_o  out  ADDR_WIDTH  read address to instruction memory (= current PC)
- imem_data_i  in  ADDR_WIDTH  instruction word from memory, combinational in same cycle
- stall_i  in  1  hazard unit: hold PC and IF/ID contents
- flush_i  in  1  squash the IF/ID entry (bubble next cycle)
- redirect_valid_i  in  1  branch/jump taken, resolved in EX
- redirect_pc_i  in  ADDR_WIDTH  target PC
- if_id_pc_o  out  ADDR_WIDTH  PC of instruction in IF/ID
- if_id_pc4_o  out  ADDR_WIDTH  PC+4 of instruction in IF/ID
- if_id_instr_o  out  ADDR_WIDTH  instruction in IF/ID
- if_id_valid_o  out  1  IF/ID entry is a real instruction
- misalign_o  out  1  pulse: last accepted redirect target had nonzero bits [1:0]
- fetch_cnt_o  out  32  count of instructions accepted into IF/ID

Behaviour:
- Reset values (async, while rst_n=0):
  - PC=RESET_PC, state=BOOT
  - if_id_pc_o=0, if_id_pc4_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0
  - misalign_o=0, fetch_cnt_o=0
- imem_addr_o is combinational from the PC register at all times.
- State machine:
  - BOOT: one cycle after reset release, because memory contents become valid only after its first clock edge.
    - PC holds; IF/ID loads bubble.
    - Next state RUN unconditionally; stall/flush/redirect are ignored in BOOT.
  - RUN: normal operation; never leaves RUN except via reset.
- RUN, per rising edge, priority highest first:
  1. redirect_valid_i=1:
     - PC <= {redirect_pc_i[31:2],2'b00}.
     - IF/ID <= bubble (valid=0, instr=NOP_INSTR).
     - misalign_o <= |redirect_pc_i[1:0].
     - Wins over stall_i and flush_i.
  2. flush_i=1 (no redirect):
     - IF/ID <= bubble.
     - PC <= PC+4 if stall_i=0, else PC holds.
  3. stall_i=1: PC and all IF/ID outputs hold.
  4. Otherwise:
     - PC <= PC+4.
     - IF/ID <= {pc=PC, pc4=PC+4, instr=imem_data_i, valid=1}.
     - fetch_cnt_o += 1.
- misalign_o is a one-cycle registered pulse; it is 0 in every cycle not immediately following a redirect.
- Arithmetic:
  - PC+4 is modulo 2^ADDR_WIDTH; PC 32'hFFFF_FFFC wraps to 0 without error.
  - fetch_cnt_o wraps modulo 2^32.
- PC bits [1:0] are always 0.
- Latency: an instruction at address A appears on if_id_* one edge after PC=A, provided no stall/flush/redirect in that cycle.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; BOOT cycle repeats after release.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR constant
  - RESET_PC default
  - fetch_state_e enum {BOOT, RUN}
  - if_id_t packed struct {pc, pc4, instr, valid}, reused by the decode stage
- One natural sub-module: pc_reg, holding the PC register, next-PC mux and misalign flag.
- IF/ID capture, FSM and counter stay in if_stage.

Test Plan:
- Reset then release, imem returns 32'h00500093 at addr 0:
  - Cycle 1 (BOOT): valid=0, PC=0.
  - Cycle 2: PC=4, if_id_instr=00500093, pc=0, valid=1, fetch_cnt=1.
- Free-run 4 cycles after BOOT → PC sequence 0,4,8,12,16; if_id_pc lags by one cycle; fetch_cnt=4.
- stall_i=1 for 2 cycles with PC=8 → PC stays 8, IF/ID unchanged, fetch_cnt unchanged; release → PC=12 next edge.
- redirect_valid_i=1, redirect_pc_i=32'h40 together with stall_i=1 → PC=0x40, valid=0, instr=NOP; next cycle if_id_pc=0x40, valid=1.
- redirect_pc_i=32'h42 → PC=0x40, misalign_o=1 for exactly one cycle.
- PC forced to 32'hFFFF_FFFC via redirect → next PC=0, no misalign; assert rst_n=0 mid-run → outputs at reset values in the same cycle, BOOT repeats.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: fetch constants, fetch FSM encoding and
// the IF/ID pipeline register layout consumed by the decode stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  // A bubble keeps the PC fields of the entry it replaces; only valid and
  // instr carry meaning for an invalid slot.
  function automatic if_id_t make_bubble(input if_id_t cur);
    if_id_t b;
    b       = cur;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC selection and a one-cycle misaligned-redirect
// flag. Only advances while the fetch stage is running.
module pc_reg
  import riscv_pkg::*;
#(
  parameter int unsigned     ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc4_o,
  output logic                  misalign_o
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic                  misalign_q, misalign_d;

  // Wraps silently at the top of the address space.
  assign pc_plus4       = pc_q + ADDR_WIDTH'(4);
  assign target_aligned = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (run_i) begin
      if (redirect_valid_i) begin
        pc_d       = target_aligned;
        misalign_d = |redirect_pc_i[1:0];
      end else if (!stall_i) begin
        // A flush without stall still advances; with stall it holds.
        pc_d = pc_plus4;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc4_o      = pc_plus4;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: boot-wait FSM, IF/ID capture register and the
// accepted-instruction counter around the pc_reg program counter.
module if_stage
  import riscv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter logic [ADDR_WIDTH-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [ADDR_WIDTH-1:0] imem_data_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] if_id_pc_o,
  output logic [ADDR_WIDTH-1:0] if_id_pc4_o,
  output logic [ADDR_WIDTH-1:0] if_id_instr_o,
  output logic                  if_id_valid_o,
  output logic                  misalign_o,
  output logic [31:0]           fetch_cnt_o
);

  localparam logic [0:0] S_BOOT = 1'(BOOT);
  localparam logic [0:0] S_RUN  = 1'(RUN);

  logic [0:0]            state_q, state_d;
  if_id_t                if_id_q, if_id_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc4;
  logic                  run;

  assign run = (state_q == S_RUN);

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .run_i            (run),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_o             (pc),
    .pc4_o            (pc4),
    .misalign_o       (misalign_o)
  );

  // BOOT lasts exactly one cycle: memory output is only valid after its
  // first clock edge, so that cycle always loads a bubble.
  always_comb begin
    state_d     = S_RUN;
    if_id_d     = if_id_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!run || redirect_valid_i || flush_i) begin
      if_id_d = make_bubble(if_id_q);
    end else if (!stall_i) begin
      if_id_d.pc    = pc;
      if_id_d.pc4   = pc4;
      if_id_d.instr = imem_data_i;
      if_id_d.valid = 1'b1;
      fetch_cnt_d   = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      if_id_q     <= '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      if_id_q     <= if_id_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_addr_o   = pc;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;
  assign fetch_cnt_o   = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a table of per-cycle vectors feeds a
// scoreboard queue, plus hand-written reset/boot sequences.
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        stall, flush, redir_v;
  logic [31:0] redir_pc;
  logic [31:0] ipc, ipc4, iinstr, fcnt;
  logic        ival, mis;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory model: address 0 holds addi x1,x0,5.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  assign imem_data = mem(imem_addr);

  if_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr_o      (imem_addr),
    .imem_data_i      (imem_data),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_valid_i (redir_v),
    .redirect_pc_i    (redir_pc),
    .if_id_pc_o       (ipc),
    .if_id_pc4_o      (ipc4),
    .if_id_instr_o    (iinstr),
    .if_id_valid_o    (ival),
    .misalign_o       (mis),
    .fetch_cnt_o      (fcnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic        st, fl, rv;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_ipc;
    logic        e_val, e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] pc, ipc, instr, cnt;
    logic        val, mis;
  } exp_t;

  exp_t sb_q[$];

  function automatic vec_t mk(input logic st, fl, rv, input logic [31:0] rpc,
                              input logic [31:0] e_pc, e_ipc, input logic e_val,
                              input logic e_mis, input logic [31:0] e_cnt);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_val = e_val; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Drive one cycle's inputs (called away from the edge), queue the expected
  // post-edge state, then compare just after the rising edge.
  task automatic step(input string tag, input vec_t v);
    exp_t e, got;
    stall = v.st; flush = v.fl; redir_v = v.rv; redir_pc = v.rpc;
    e.tag   = tag;
    e.pc    = v.e_pc;
    e.ipc   = v.e_ipc;
    e.val   = v.e_val;
    e.mis   = v.e_mis;
    e.cnt   = v.e_cnt;
    e.instr = v.e_val ? mem(v.e_ipc) : NOP_INSTR;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.sb: scoreboard empty", tag);
    end else begin
      got = sb_q.pop_front();
      check({got.tag, ".pc"},    imem_addr,   got.pc);
      check({got.tag, ".valid"}, 32'(ival),   32'(got.val));
      check({got.tag, ".instr"}, iinstr,      got.instr);
      check({got.tag, ".mis"},   32'(mis),    32'(got.mis));
      check({got.tag, ".cnt"},   fcnt,        got.cnt);
      if (got.val) begin
        check({got.tag, ".ifpc"},  ipc,  got.ipc);
        check({got.tag, ".ifpc4"}, ipc4, got.ipc + 32'd4);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc"},    imem_addr, 32'h0);
    check({tag, ".ifpc"},  ipc,       32'h0);
    check({tag, ".ifpc4"}, ipc4,      32'h0);
    check({tag, ".instr"}, iinstr,    NOP_INSTR);
    check({tag, ".valid"}, 32'(ival), 32'h0);
    check({tag, ".mis"},   32'(mis),  32'h0);
    check({tag, ".cnt"},   fcnt,      32'h0);
  endtask

  vec_t vecs[$];

  initial begin
    //            st fl rv rpc            pc            ifpc          val mis cnt
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));  // BOOT
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        32'h4,        1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'hC,        32'h8,        1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h10,       32'hC,        1, 0, 4));
    vecs.push_back(mk(0, 0, 1, 32'h4,        32'h4,        32'hC,        0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        32'h4,        1, 0, 5));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h8,        32'h4,        1, 0, 5));  // stall
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h8,        32'h4,        1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'hC,        32'h8,        1, 0, 6));
    vecs.push_back(mk(1, 0, 1, 32'h40,       32'h40,       32'h8,        0, 0, 6));  // redirect beats stall
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h44,       32'h40,       1, 0, 7));
    vecs.push_back(mk(0, 0, 1, 32'h42,       32'h40,       32'h40,       0, 1, 7));  // misaligned
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h44,       32'h40,       1, 0, 8));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h48,       32'h40,       0, 0, 8));  // flush
    vecs.push_back(mk(1, 1, 0, 32'h0,        32'h48,       32'h40,       0, 0, 8));  // flush+stall
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4C,       32'h48,       1, 0, 9));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h48,     0, 0, 9));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 1, 0, 10)); // wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        32'h0,        1, 0, 11));
    vecs.push_back(mk(0, 0, 1, 32'h13,       32'h10,       32'h0,        0, 1, 11));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h14,       32'h10,       1, 0, 12));

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redir_v = 1'b0; redir_pc = 32'h0;
    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("v%0d", i), vecs[i]);

    // Asynchronous reset in the middle of a cycle, away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    // BOOT must ignore every control input, including a misaligned redirect.
    step("boot2", mk(1, 1, 1, 32'h42, 32'h0, 32'h0, 0, 0, 0));
    step("run2a", mk(0, 0, 0, 32'h0,  32'h4, 32'h0, 1, 0, 1));
    step("run2b", mk(0, 0, 0, 32'h0,  32'h8, 32'h4, 1, 0, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
